// File: rtl/uart_pkg.sv
// Shared UART definitions: default line parameters (common with the transmitter),
// the bit-period counter width and the receiver state encoding.
package uart_pkg;

  localparam int unsigned SYSFREQ_DEFAULT  = 50_000_000;
  localparam int unsigned BAUDRATE_DEFAULT = 115_200;
  localparam int unsigned CNT_W            = 10;

  // Prefixed so the DATA state cannot collide with the DATA port.
  typedef enum logic [2:0] {
    S_WAIT_HIGH = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_STOP      = 3'd4
  } rx_state_e;

  function automatic int unsigned cycles_per_bit(input int unsigned freq,
                                                 input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line; resets to the idle-high level.
module uart_rx_sync (
  input  logic SYSCLK,
  input  logic RST_N,
  input  logic D,
  output logic Q
);

  logic meta;

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values and the two stages cannot collapse into one.
  always_ff @(posedge SYSCLK) begin
    if (!RST_N) begin
      meta <= 1'b1;
      Q    <= 1'b1;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB-first assembly, stop-bit check,
// byte held for the host with ready/overrun/framing-error status.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned sysfreq      = SYSFREQ_DEFAULT,
  parameter int unsigned baudrate     = BAUDRATE_DEFAULT,
  parameter int unsigned counterLimit = cycles_per_bit(sysfreq, baudrate),
  parameter int unsigned halfLimit    = counterLimit / 2
) (
  input  logic       SYSCLK,
  input  logic       RST_N,
  input  logic       RX_PIN,
  output logic [7:0] DATA,
  output logic       DATA_READY,
  input  logic       READ,
  output logic       BUSY_FLAG,
  output logic       ERROR_FLAG,
  output logic       OVERRUN_FLAG
);

  // counterLimit must lie in [4, 1023] so both terminal counts fit the counter.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(counterLimit - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(halfLimit - 1);

  logic             rx_s;
  rx_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_q, data_n;
  logic             ready_q, ready_n;
  logic             err_q, err_n;
  logic             ovr_q, ovr_n;

  uart_rx_sync u_sync (
    .SYSCLK (SYSCLK),
    .RST_N  (RST_N),
    .D      (RX_PIN),
    .Q      (rx_s)
  );

  always_ff @(posedge SYSCLK) begin
    if (!RST_N) begin
      state   <= S_WAIT_HIGH;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      data_q  <= data_n;
      ready_q <= ready_n;
      err_q   <= err_n;
      ovr_q   <= ovr_n;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    data_n    = data_q;
    ready_n   = ready_q;
    err_n     = 1'b0;
    ovr_n     = ovr_q;

    if (READ && ready_q) begin
      ready_n = 1'b0;
      ovr_n   = 1'b0;
    end

    unique case (state)
      S_WAIT_HIGH: begin
        if (rx_s) state_n = S_IDLE;
      end

      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end

      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          state_n   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          shift_n   = {rx_s, shift[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = S_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            // A concurrent READ acknowledges the old byte, so no overrun then.
            data_n  = shift;
            ready_n = 1'b1;
            if (ready_q && !READ) ovr_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = S_WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: state_n = S_WAIT_HIGH;
    endcase
  end

  assign DATA         = data_q;
  assign DATA_READY   = ready_q;
  assign ERROR_FLAG   = err_q;
  assign OVERRUN_FLAG = ovr_q;
  assign BUSY_FLAG    = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random bytes against
// a host-visible model (held byte, ready, overrun) and frame-level timing.
module tb_uart_rx;

  localparam int CL        = 50_000_000 / 115_200;
  localparam int HL        = CL / 2;
  localparam int READY_LAT = 2 + HL + 9 * CL + 1;

  logic       SYSCLK = 1'b0;
  logic       RST_N  = 1'b0;
  logic       RX_PIN = 1'b1;
  logic       READ   = 1'b0;
  logic [7:0] DATA;
  logic       DATA_READY, BUSY_FLAG, ERROR_FLAG, OVERRUN_FLAG;

  uart_rx dut (
    .SYSCLK       (SYSCLK),
    .RST_N        (RST_N),
    .RX_PIN       (RX_PIN),
    .DATA         (DATA),
    .DATA_READY   (DATA_READY),
    .READ         (READ),
    .BUSY_FLAG    (BUSY_FLAG),
    .ERROR_FLAG   (ERROR_FLAG),
    .OVERRUN_FLAG (OVERRUN_FLAG)
  );

  always #5 SYSCLK = ~SYSCLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge SYSCLK) cyc <= cyc + 1;

  logic prev_ready = 1'b0;
  logic prev_err   = 1'b0;
  int   rise_cyc   = -1;
  int   err_cyc    = -1;
  int   err_cnt    = 0;
  int   err_wide   = 0;

  always @(negedge SYSCLK) begin
    if (DATA_READY && !prev_ready) rise_cyc = cyc;
    if (ERROR_FLAG) begin
      err_cnt++;
      if (prev_err) err_wide++;
      err_cyc = cyc;
    end
    prev_ready = DATA_READY;
    prev_err   = ERROR_FLAG;
  end

  // Host-visible reference state.
  logic [7:0] m_data  = 8'h00;
  logic       m_ready = 1'b0;
  logic       m_ovr   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_host(input string tag);
    check({tag, "_data"}, 32'(DATA), 32'(m_data));
    check({tag, "_ready"}, 32'(DATA_READY), 32'(m_ready));
    check({tag, "_ovr"}, 32'(OVERRUN_FLAG), 32'(m_ovr));
  endtask

  // Called right after a negedge; line goes low immediately.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    RX_PIN = 1'b0;
    repeat (CL) @(negedge SYSCLK);
    for (int i = 0; i < 8; i++) begin
      RX_PIN = b[i];
      repeat (CL) @(negedge SYSCLK);
    end
    RX_PIN = stop_bit;
    repeat (CL) @(negedge SYSCLK);
  endtask

  task automatic good_frame(input logic [7:0] b, input logic read_at_stop, input string tag);
    int  fall;
    int  e0;
    logic was_ready;
    @(negedge SYSCLK);
    fall      = cyc;
    rise_cyc  = -1;
    e0        = err_cnt;
    was_ready = m_ready;
    fork
      drive_frame(b, 1'b1);
      if (read_at_stop) begin
        repeat (READY_LAT - 1) @(negedge SYSCLK);
        READ = 1'b1;
        @(negedge SYSCLK);
        READ = 1'b0;
      end
    join
    if (read_at_stop && m_ready) m_ovr = 1'b0;
    else if (m_ready) m_ovr = 1'b1;
    m_data  = b;
    m_ready = 1'b1;
    check_host(tag);
    if (!was_ready) check({tag, "_latency"}, 32'(rise_cyc - fall), 32'(READY_LAT));
    check({tag, "_busy"}, 32'(BUSY_FLAG), 32'd0);
    check({tag, "_noerr"}, 32'(err_cnt - e0), 32'd0);
  endtask

  task automatic host_read(input string tag);
    @(negedge SYSCLK);
    READ = 1'b1;
    @(negedge SYSCLK);
    READ = 1'b0;
    if (m_ready) begin
      m_ready = 1'b0;
      m_ovr   = 1'b0;
    end
    check_host(tag);
  endtask

  initial begin
    int fall;
    int e0;

    // Reset state
    repeat (4) @(negedge SYSCLK);
    check_host("reset");
    check("reset_err", 32'(ERROR_FLAG), 32'd0);
    check("reset_busy", 32'(BUSY_FLAG), 32'd1);
    RST_N = 1'b1;
    repeat (5) @(negedge SYSCLK);
    check("idle_busy", 32'(BUSY_FLAG), 32'd0);

    // Good byte
    good_frame(8'hA5, 1'b0, "a5");
    host_read("a5_read");

    // Glitch rejection
    e0 = err_cnt;
    @(negedge SYSCLK);
    RX_PIN = 1'b0;
    repeat (100) @(negedge SYSCLK);
    check("glitch_busy_hi", 32'(BUSY_FLAG), 32'd1);
    RX_PIN = 1'b1;
    repeat (400) @(negedge SYSCLK);
    check("glitch_busy_lo", 32'(BUSY_FLAG), 32'd0);
    check("glitch_ready", 32'(DATA_READY), 32'd0);
    check("glitch_noerr", 32'(err_cnt - e0), 32'd0);

    // Framing error, line held low afterwards
    e0 = err_cnt;
    @(negedge SYSCLK);
    fall = cyc;
    drive_frame(8'h3C, 1'b0);
    repeat (2 * CL) @(negedge SYSCLK);
    check("frm_err_count", 32'(err_cnt - e0), 32'd1);
    check("frm_err_width", 32'(err_wide), 32'd0);
    check("frm_err_time", 32'(err_cyc - fall), 32'(READY_LAT));
    check_host("frm");
    check("frm_wait_busy", 32'(BUSY_FLAG), 32'd1);
    RX_PIN = 1'b1;
    repeat (10) @(negedge SYSCLK);
    check("frm_recover_busy", 32'(BUSY_FLAG), 32'd0);

    // Overrun
    good_frame(8'h11, 1'b0, "ovr_11");
    good_frame(8'h22, 1'b0, "ovr_22");
    host_read("ovr_read");

    // READ coincident with the stop sample
    good_frame(8'h11, 1'b0, "coin_11");
    good_frame(8'h22, 1'b1, "coin_22");

    // Reset mid-frame (byte 0x22 still held and unread)
    @(negedge SYSCLK);
    RX_PIN = 1'b0;
    repeat (CL) @(negedge SYSCLK);
    RX_PIN = 1'b1;
    repeat (4 * CL + HL) @(negedge SYSCLK);
    RX_PIN = 1'b0;
    RST_N  = 1'b0;
    repeat (3) @(negedge SYSCLK);
    m_data  = 8'h00;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    check_host("midrst");
    check("midrst_err", 32'(ERROR_FLAG), 32'd0);
    check("midrst_busy", 32'(BUSY_FLAG), 32'd1);
    RX_PIN = 1'b1;
    repeat (2) @(negedge SYSCLK);
    RST_N = 1'b1;
    repeat (20) @(negedge SYSCLK);
    check("midrst_idle", 32'(BUSY_FLAG), 32'd0);
    good_frame(8'h5A, 1'b0, "after_rst");

    // Random bytes with random host reads
    for (int n = 0; n < 5; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      good_frame(b, 1'b0, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) host_read($sformatf("rnd%0d_read", n));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
